// File: rtl/copy_engine_ctrl.sv
// copy_engine_ctrl: control plane of a cache-line copy engine.
// Accepts MMIO configuration and commands and issues cache-line reads from src.
// Each read response produces one write to dst at the same line index.
// When all lines are written, the engine issues one completion (DSM) write to
// dsm_base+1 and raises done.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   csr_wr_*              MMIO writes: 0x110 dsm_base, 0x120 src, 0x128 dst,
//                         0x130 num_lines, 0x138 CTL
//   c0_almfull/c1_almfull read / write request channel back-pressure
//   rd_req_*, rd_rsp_*    read request issue and read response
//   wr_req_*, wr_rsp_valid write request issue and write response
//   busy, done            transfer in progress / completion written
//   perf_cycles           (only with COPY_CTRL_PERF_CNT_EN) active-cycle counter
//
// Optional feature macro: COPY_CTRL_PERF_CNT_EN.
module copy_engine_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_wr_valid,
    input  logic [15:0] csr_wr_addr,
    input  logic [63:0] csr_wr_data,
    input  logic        c0_almfull,
    input  logic        c1_almfull,
    output logic        rd_req_valid,
    output logic [41:0] rd_req_addr,
    output logic [15:0] rd_req_mdata,
    input  logic        rd_rsp_valid,
    input  logic [15:0] rd_rsp_mdata,
    output logic        wr_req_valid,
    output logic [41:0] wr_req_addr,
    output logic [15:0] wr_req_mdata,
    output logic        wr_req_dsm,
    input  logic        wr_rsp_valid,
    output logic        busy,
    output logic        done
`ifdef COPY_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned CW = 17;
    localparam logic [CW-1:0] MAX_LINES = 17'h10000;

    typedef enum logic [2:0] {
        S_HELD, S_IDLE, S_RUN, S_DRAIN, S_DSM, S_WAIT_DSM, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [41:0]   r_dsm_base;
    logic [41:0]   r_src;
    logic [41:0]   r_dst;
    logic [CW-1:0] r_num_lines;
    logic [CW-1:0] r_issued;
    logic [OW-1:0] r_outstanding;
    logic [CW-1:0] r_wr_issued;
    logic [CW-1:0] r_wr_rsp_cnt;
    logic          r_rd_req_valid;
    logic [41:0]   r_rd_req_addr;
    logic [15:0]   r_rd_req_mdata;
    logic          r_wr_req_valid;
    logic [41:0]   r_wr_req_addr;
    logic [15:0]   r_wr_req_mdata;
    logic          r_wr_req_dsm;
    logic          r_busy;
    logic          r_done;

    // Command decode; CTL writes are honoured even while busy
    logic        w_ctl_wr;
    logic [31:0] w_ctl_val;
    logic        w_cmd_hold, w_cmd_enable, w_cmd_start, w_cmd_drain, w_clr;
    logic        w_cfg_wr, w_rsp_active, w_rd_issue, w_rd_rsp, w_wr_rsp, w_dsm_issue;
    logic        w_unused_data;

    assign w_ctl_wr     = csr_wr_valid && (csr_wr_addr == 16'h0138);
    assign w_ctl_val    = csr_wr_data[31:0];
    assign w_cmd_hold   = w_ctl_wr && (w_ctl_val == 32'd0);
    assign w_cmd_enable = w_ctl_wr && (w_ctl_val == 32'd1) && (r_state == S_HELD);
    assign w_cmd_start  = w_ctl_wr && (w_ctl_val == 32'd3) &&
                          ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cmd_drain  = w_ctl_wr && (w_ctl_val == 32'd7) && (r_state == S_RUN);
    assign w_clr        = w_cmd_hold || w_cmd_start;
    assign w_cfg_wr     = csr_wr_valid && !r_busy;
    assign w_unused_data = ^csr_wr_data[63:48];

    // Responses only matter while a copy is in flight; a hold command cancels this cycle's work
    assign w_rsp_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_rd_issue   = (r_state == S_RUN) && (r_issued < r_num_lines) && !c0_almfull &&
                          !c1_almfull && (r_outstanding < OW'(MAX_OUTSTANDING)) && !w_cmd_hold;
    assign w_rd_rsp     = rd_rsp_valid && w_rsp_active && !w_cmd_hold;
    assign w_wr_rsp     = wr_rsp_valid && w_rsp_active && !w_cmd_hold;
    assign w_dsm_issue  = (r_state == S_DSM) && !c1_almfull && !w_cmd_hold;

    // Next-state selection: commands first, then protocol progress
    always_comb begin
        w_state_nxt = r_state;
        if (w_cmd_hold) begin
            w_state_nxt = S_HELD;
        end else if (w_cmd_enable) begin
            w_state_nxt = S_IDLE;
        end else if (w_cmd_start) begin
            w_state_nxt = S_RUN;
        end else if (w_cmd_drain) begin
            w_state_nxt = S_DRAIN;
        end else begin
            case (r_state)
                S_RUN:      if (r_wr_rsp_cnt == r_num_lines) w_state_nxt = S_DSM;
                S_DRAIN:    if ((r_outstanding == '0) && (r_wr_rsp_cnt == r_wr_issued))
                                w_state_nxt = S_IDLE;
                S_DSM:      if (!c1_almfull) w_state_nxt = S_WAIT_DSM;
                S_WAIT_DSM: if (wr_rsp_valid) w_state_nxt = S_DONE;
                default:    ;
            endcase
        end
    end

    // State, counters, configuration and registered request outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_HELD;
            r_dsm_base     <= '0;
            r_src          <= '0;
            r_dst          <= '0;
            r_num_lines    <= '0;
            r_issued       <= '0;
            r_outstanding  <= '0;
            r_wr_issued    <= '0;
            r_wr_rsp_cnt   <= '0;
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_rd_req_mdata <= '0;
            r_wr_req_valid <= 1'b0;
            r_wr_req_addr  <= '0;
            r_wr_req_mdata <= '0;
            r_wr_req_dsm   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN) ||
                       (w_state_nxt == S_DSM) || (w_state_nxt == S_WAIT_DSM);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_cfg_wr) begin
                case (csr_wr_addr)
                    16'h0110: r_dsm_base <= 42'(csr_wr_data[31:6]);
                    16'h0120: r_src      <= csr_wr_data[47:6];
                    16'h0128: r_dst      <= csr_wr_data[47:6];
                    16'h0130: r_num_lines <= (csr_wr_data[31:0] > 32'h0001_0000) ?
                                             MAX_LINES : csr_wr_data[16:0];
                    default:  ;
                endcase
            end

            if (w_clr) begin
                r_issued      <= '0;
                r_outstanding <= '0;
                r_wr_issued   <= '0;
                r_wr_rsp_cnt  <= '0;
            end else begin
                if (w_rd_issue) r_issued <= r_issued + 1'b1;
                case ({w_rd_issue, w_rd_rsp})
                    2'b10:   r_outstanding <= r_outstanding + 1'b1;
                    2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                    default: ;
                endcase
                if (w_rd_rsp) r_wr_issued  <= r_wr_issued + 1'b1;
                if (w_wr_rsp) r_wr_rsp_cnt <= r_wr_rsp_cnt + 1'b1;
            end

            r_rd_req_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_req_addr  <= r_src + 42'(r_issued);
                r_rd_req_mdata <= r_issued[15:0];
            end

            // Copy writes ignore c1_almfull; only the DSM write waits for it
            r_wr_req_valid <= w_rd_rsp || w_dsm_issue;
            if (w_rd_rsp) begin
                r_wr_req_addr  <= r_dst + 42'(rd_rsp_mdata);
                r_wr_req_mdata <= rd_rsp_mdata;
                r_wr_req_dsm   <= 1'b0;
            end else if (w_dsm_issue) begin
                r_wr_req_addr  <= r_dsm_base + 42'd1;
                r_wr_req_mdata <= 16'hFFFF;
                r_wr_req_dsm   <= 1'b1;
            end
        end
    end

    assign rd_req_valid = r_rd_req_valid;
    assign rd_req_addr  = r_rd_req_addr;
    assign rd_req_mdata = r_rd_req_mdata;
    assign wr_req_valid = r_wr_req_valid;
    assign wr_req_addr  = r_wr_req_addr;
    assign wr_req_mdata = r_wr_req_mdata;
    assign wr_req_dsm   = r_wr_req_dsm;
    assign busy         = r_busy;
    assign done         = r_done;

`ifdef COPY_CTRL_PERF_CNT_EN
    // Saturating count of cycles spent moving data or completing
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cycles <= '0;
        end else if (w_cmd_start) begin
            r_perf_cycles <= '0;
        end else if (((r_state == S_RUN) || (r_state == S_DSM) || (r_state == S_WAIT_DSM)) &&
                     (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`else
    // No performance counter in this build
`endif

endmodule

// File: tb/tb_copy_engine_ctrl.sv
// Directed self-checking bench for copy_engine_ctrl.
// u_dut uses the default MAX_OUTSTANDING; u_dut2 (MAX_OUTSTANDING=2) shares
// all inputs and is only observed for the outstanding-limit scenario.
module tb_copy_engine_ctrl;

    logic        clk;
    logic        reset;
    logic        csr_wr_valid;
    logic [15:0] csr_wr_addr;
    logic [63:0] csr_wr_data;
    logic        c0_almfull, c1_almfull;
    logic        rd_rsp_valid;
    logic [15:0] rd_rsp_mdata;
    logic        wr_rsp_valid;

    logic        rd_req_valid, wr_req_valid, wr_req_dsm, busy, done;
    logic [41:0] rd_req_addr, wr_req_addr;
    logic [15:0] rd_req_mdata, wr_req_mdata;

    logic        m2_rd_req_valid, m2_wr_req_valid, m2_wr_req_dsm, m2_busy, m2_done;
    logic [41:0] m2_rd_req_addr, m2_wr_req_addr;
    logic [15:0] m2_rd_req_mdata, m2_wr_req_mdata;
`ifdef COPY_CTRL_PERF_CNT_EN
    logic [31:0] perf_cycles, m2_perf_cycles;
`endif

    copy_engine_ctrl u_dut (
        .clk(clk), .reset(reset),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
        .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
        .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata),
        .wr_req_dsm(wr_req_dsm), .wr_rsp_valid(wr_rsp_valid),
        .busy(busy), .done(done)
`ifdef COPY_CTRL_PERF_CNT_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    copy_engine_ctrl #(.MAX_OUTSTANDING(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr), .csr_wr_data(csr_wr_data),
        .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
        .rd_req_valid(m2_rd_req_valid), .rd_req_addr(m2_rd_req_addr),
        .rd_req_mdata(m2_rd_req_mdata),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
        .wr_req_valid(m2_wr_req_valid), .wr_req_addr(m2_wr_req_addr),
        .wr_req_mdata(m2_wr_req_mdata),
        .wr_req_dsm(m2_wr_req_dsm), .wr_rsp_valid(wr_rsp_valid),
        .busy(m2_busy), .done(m2_done)
`ifdef COPY_CTRL_PERF_CNT_EN
        , .perf_cycles(m2_perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request logs, appended on the falling edge; tests look at entries past a base index
    logic [41:0] rd_addr_q[$];
    logic [15:0] rd_mdata_q[$];
    logic [41:0] wr_addr_q[$];
    logic [15:0] wr_mdata_q[$];
    logic        wr_dsm_q[$];
    int          m2_rd_cnt = 0;
    int          rd_base, wr_base, m2_base;

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_req_valid) begin
                rd_addr_q.push_back(rd_req_addr);
                rd_mdata_q.push_back(rd_req_mdata);
            end
            if (wr_req_valid) begin
                wr_addr_q.push_back(wr_req_addr);
                wr_mdata_q.push_back(wr_req_mdata);
                wr_dsm_q.push_back(wr_req_dsm);
            end
            if (m2_rd_req_valid) m2_rd_cnt = m2_rd_cnt + 1;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap_base();
        rd_base = rd_addr_q.size();
        wr_base = wr_addr_q.size();
        m2_base = m2_rd_cnt;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        snap_base();
    endtask

    task automatic csr_wr(input logic [15:0] a, input logic [63:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_addr  = a;
        csr_wr_data  = d;
        step(1);
        csr_wr_valid = 1'b0;
    endtask

    task automatic configure(input logic [41:0] src, input logic [41:0] dst,
                             input logic [25:0] dsm, input logic [31:0] n);
        csr_wr(16'h0110, {32'h0, dsm, 6'h0});
        csr_wr(16'h0120, {16'h0, src, 6'h0});
        csr_wr(16'h0128, {16'h0, dst, 6'h0});
        csr_wr(16'h0130, {32'h0, n});
    endtask

    task automatic start_xfer();
        csr_wr(16'h0138, 64'd1);
        csr_wr(16'h0138, 64'd3);
    endtask

    task automatic send_rd(input logic [15:0] tag);
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = tag;
        step(1);
        rd_rsp_valid = 1'b0;
    endtask

    task automatic send_wr();
        wr_rsp_valid = 1'b1;
        step(1);
        wr_rsp_valid = 1'b0;
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while ((wr_addr_q.size() - wr_base) < n && k < budget) begin
            step(1);
            k++;
        end
        check_val("wait_wr", 64'(wr_addr_q.size() - wr_base), 64'(n));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [41:0] exp_ooo[4];
        exp_ooo[0] = 42'h2003; exp_ooo[1] = 42'h2000;
        exp_ooo[2] = 42'h2002; exp_ooo[3] = 42'h2001;

        reset = 1'b1; csr_wr_valid = 1'b0; csr_wr_addr = '0; csr_wr_data = '0;
        c0_almfull = 1'b0; c1_almfull = 1'b0;
        rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; wr_rsp_valid = 1'b0;
        do_reset();

        // Reset state
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_rdv", 64'(rd_req_valid), 64'd0);
        check_val("rst_wrv", 64'(wr_req_valid), 64'd0);

        // In-order copy of 4 lines
        configure(42'h1000, 42'h2000, 26'h200, 32'd4);
        start_xfer();
        check_val("t1_busy", 64'(busy), 64'd1);
        step(8);
        check_val("t1_rd_cnt", 64'(rd_addr_q.size() - rd_base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t1_rd_addr%0d", i), 64'(rd_addr_q[rd_base + i]), 64'h1000 + 64'(i));
            check_val($sformatf("t1_rd_tag%0d", i), 64'(rd_mdata_q[rd_base + i]), 64'(i));
        end
        for (int i = 0; i < 4; i++) send_rd(16'(i));
        step(2);
        check_val("t1_wr_cnt", 64'(wr_addr_q.size() - wr_base), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t1_wr_addr%0d", i), 64'(wr_addr_q[wr_base + i]), 64'h2000 + 64'(i));
            check_val($sformatf("t1_wr_dsm%0d", i), 64'(wr_dsm_q[wr_base + i]), 64'd0);
        end
        for (int i = 0; i < 4; i++) send_wr();
        wait_wr(5, 20);
        check_val("t1_dsm_addr", 64'(wr_addr_q[wr_base + 4]), 64'h201);
        check_val("t1_dsm_tag", 64'(wr_mdata_q[wr_base + 4]), 64'hFFFF);
        check_val("t1_dsm_bit", 64'(wr_dsm_q[wr_base + 4]), 64'd1);
        send_wr();
        check_val("t1_done", 64'(done), 64'd1);
        check_val("t1_busy_end", 64'(busy), 64'd0);

        // Restart from DONE, out-of-order responses 3,0,2,1
        snap_base();
        csr_wr(16'h0138, 64'd3);
        check_val("t2_done_clr", 64'(done), 64'd0);
        step(8);
        check_val("t2_rd_cnt", 64'(rd_addr_q.size() - rd_base), 64'd4);
        send_rd(16'd3); send_rd(16'd0); send_rd(16'd2); send_rd(16'd1);
        step(2);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t2_wr_addr%0d", i), 64'(wr_addr_q[wr_base + i]), 64'(exp_ooo[i]));
        for (int i = 0; i < 4; i++) send_wr();
        wait_wr(5, 20);
        send_wr();
        check_val("t2_done", 64'(done), 64'd1);

        // Outstanding limit of 2 on the second instance
        do_reset();
        configure(42'h1000, 42'h2000, 26'h200, 32'd8);
        start_xfer();
        step(10);
        check_val("t3_m2_rd2", 64'(m2_rd_cnt - m2_base), 64'd2);
        send_rd(16'd0);
        step(3);
        check_val("t3_m2_rd3", 64'(m2_rd_cnt - m2_base), 64'd3);
        send_rd(16'd1);
        step(3);
        check_val("t3_m2_rd4", 64'(m2_rd_cnt - m2_base), 64'd4);

        // Write channel back-pressure in RUN and in DSM
        do_reset();
        configure(42'h1000, 42'h2000, 26'h200, 32'd2);
        c1_almfull = 1'b1;
        start_xfer();
        step(10);
        check_val("t4_rd_held", 64'(rd_addr_q.size() - rd_base), 64'd0);
        c1_almfull = 1'b0;
        step(4);
        check_val("t4_rd_cnt", 64'(rd_addr_q.size() - rd_base), 64'd2);
        send_rd(16'd0); send_rd(16'd1);
        step(2);
        send_wr(); send_wr();
        c1_almfull = 1'b1;
        step(10);
        check_val("t4_dsm_held", 64'(wr_addr_q.size() - wr_base), 64'd2);
        check_val("t4_busy_held", 64'(busy), 64'd1);
        c1_almfull = 1'b0;
        wait_wr(3, 20);
        check_val("t4_dsm_bit", 64'(wr_dsm_q[wr_base + 2]), 64'd1);
        send_wr();
        check_val("t4_done", 64'(done), 64'd1);

        // Drain with 3 reads outstanding
        do_reset();
        configure(42'h1000, 42'h2000, 26'h200, 32'd8);
        start_xfer();
        step(3);
        c0_almfull = 1'b1;
        step(3);
        check_val("t5_rd_cnt", 64'(rd_addr_q.size() - rd_base), 64'd3);
        csr_wr(16'h0138, 64'd7);
        check_val("t5_busy_drain", 64'(busy), 64'd1);
        send_rd(16'd0); send_rd(16'd1); send_rd(16'd2);
        step(2);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("t5_wr_addr%0d", i), 64'(wr_addr_q[wr_base + i]), 64'h2000 + 64'(i));
        send_wr(); send_wr(); send_wr();
        step(3);
        check_val("t5_busy_idle", 64'(busy), 64'd0);
        check_val("t5_done", 64'(done), 64'd0);
        check_val("t5_wr_cnt", 64'(wr_addr_q.size() - wr_base), 64'd3);
        check_val("t5_rd_cnt_end", 64'(rd_addr_q.size() - rd_base), 64'd3);
        c0_almfull = 1'b0;

        // Asynchronous reset mid-RUN, then zero-length transfer
        do_reset();
        configure(42'h1000, 42'h2000, 26'h200, 32'd8);
        start_xfer();
        step(2);
        check_val("t6_pre_rdv", 64'(rd_req_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_rst_rdv", 64'(rd_req_valid), 64'd0);
        check_val("t6_rst_addr", 64'(rd_req_addr), 64'd0);
        check_val("t6_rst_busy", 64'(busy), 64'd0);
        check_val("t6_rst_wrv", 64'(wr_req_valid), 64'd0);
        step(1);
        reset = 1'b0;
        step(1);
        snap_base();
        send_rd(16'd0);
        step(3);
        check_val("t6_late_rsp", 64'(wr_addr_q.size() - wr_base), 64'd0);
        check_val("t6_held_busy", 64'(busy), 64'd0);
        configure(42'h1000, 42'h2000, 26'h200, 32'd0);
        start_xfer();
        step(2);
        check_val("t6_zero_wrv", 64'(wr_req_valid), 64'd1);
        check_val("t6_zero_dsm", 64'(wr_req_dsm), 64'd1);
        check_val("t6_zero_addr", 64'(wr_req_addr), 64'h201);
        step(2);
        check_val("t6_zero_rd", 64'(rd_addr_q.size() - rd_base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/copy_engine_ctrl.md
COPY_ENGINE_CTRL -- requirements
Module: copy_engine_ctrl

Interface
REQ-001 SHALL provide parameter MAX_OUTSTANDING, default 64, the maximum number of in-flight reads (power of 2, 2..512).
REQ-002 SHALL provide port clk  in  1  CCI-P clock (pClk domain), all logic rising-edge.
REQ-003 SHALL provide port reset  in  1  asynchronous active-high reset (soft reset).
REQ-004 SHALL provide port csr_wr_valid  in  1  MMIO write strobe.
REQ-005 SHALL provide port csr_wr_addr  in  16  MMIO byte address.
REQ-006 SHALL provide port csr_wr_data  in  64  MMIO write data.
REQ-007 SHALL provide port c0_almfull  in  1  read request channel almost full.
REQ-008 SHALL provide port c1_almfull  in  1  write request channel almost full.
REQ-009 SHALL provide port rd_req_valid  out  1  read request issue, one cycle per request.
REQ-010 SHALL provide port rd_req_addr  out  42  read cache-line address.
REQ-011 SHALL provide port rd_req_mdata  out  16  read tag (line index).
REQ-012 SHALL provide port rd_rsp_valid  in  1  read response strobe.
REQ-013 SHALL provide port rd_rsp_mdata  in  16  tag of the returning read.
REQ-014 SHALL provide port wr_req_valid  out  1  write request issue.
REQ-015 SHALL provide port wr_req_addr  out  42  write cache-line address.
REQ-016 SHALL provide port wr_req_mdata  out  16  write tag.
REQ-017 SHALL provide port wr_req_dsm  out  1  1 = completion write, datapath drives DSM data (bit0=1); 0 = copy data.
REQ-018 SHALL provide port wr_rsp_valid  in  1  write response strobe.
REQ-019 SHALL provide ports busy and done, each out 1: busy = transfer in progress; done = completion written.

Function
REQ-020 SHALL decode CSR writes: 0x110 dsm_base = {10'b0, data[31:6]}; 0x120 src = data[47:6]; 0x128 dst = data[47:6]; 0x130 num_lines = data[31:0] saturated to 65536; 0x138 CTL = data[31:0].
REQ-021 SHALL ignore writes to 0x110-0x130 while busy=1, and ignore writes to any other address.
REQ-022 SHALL implement states HELD, IDLE, RUN, DRAIN, DSM, WAIT_DSM, DONE.
REQ-023 SHALL act on CTL values as follows; all other CTL values are ignored.
- 0: go to HELD from any state and clear all counters.
- 1: HELD->IDLE.
- 3: IDLE/DONE->RUN, clearing counters and done.
- 7: RUN->DRAIN.
REQ-024 SHALL, in RUN, register rd_req_valid=1 when all of: issued<num_lines, !c0_almfull, !c1_almfull, outstanding<MAX_OUTSTANDING; address = src+issued (42-bit wrap), mdata = issued[15:0].
REQ-025 SHALL increment outstanding on issue and decrement it on rd_rsp_valid; on simultaneous issue and response, outstanding is unchanged.
REQ-026 SHALL, one cycle after rd_rsp_valid in RUN/DRAIN, assert wr_req_valid with address = dst+rd_rsp_mdata, mdata = rd_rsp_mdata, wr_req_dsm=0, regardless of c1_almfull.
REQ-027 SHALL leave RUN for DSM when wr_rsp count == num_lines; num_lines=0 goes to DSM on the cycle after START.
REQ-028 SHALL, in DSM with !c1_almfull, issue one write (address dsm_base+1, mdata 0xFFFF, wr_req_dsm=1), then enter WAIT_DSM.
REQ-029 SHALL go WAIT_DSM->DONE on wr_rsp_valid; done=1 in DONE only.
REQ-030 SHALL leave DRAIN for IDLE when outstanding==0 and wr_rsp count == write issue count; DRAIN issues no reads and no DSM write.
REQ-031 SHALL ignore responses in HELD/IDLE/DONE; busy=1 in RUN, DRAIN, DSM, WAIT_DSM.

Reset
REQ-032 SHALL, on reset assertion, immediately enter HELD and clear all counters, config registers, rd_req_valid, wr_req_valid, wr_req_dsm, busy, done and all address/mdata outputs to 0, independent of clk.
REQ-033 SHALL, on reset mid-transfer, abandon the transfer; late responses after release are ignored per REQ-031.

Configuration
REQ-034 SHALL, with COPY_CTRL_PERF_CNT_EN defined, add port perf_cycles (out, 32 bits): counts cycles in RUN/DSM/WAIT_DSM, clears on START, saturates at 0xFFFFFFFF, reset 0; without the macro the port and counter are absent.

Verification
REQ-035 SHALL cover: CTL 1,3 with src 0x1000, dst 0x2000 (cl), num_lines 4, in-order responses -> reads to 0x1000..0x1003, writes to 0x2000..0x2003, DSM write to dsm_base+1, done=1.
REQ-036 SHALL cover: responses in order 3,0,2,1 -> writes to dst+3, dst+0, dst+2, dst+1; completion still reached.
REQ-037 SHALL cover: MAX_OUTSTANDING=2, num_lines 8, no responses -> exactly 2 reads issued; each response releases one more read.
REQ-038 SHALL cover: c1_almfull=1 during RUN -> no reads issued; in DSM -> DSM write held until c1_almfull drops.
REQ-039 SHALL cover: CTL 7 with 3 outstanding -> DRAIN, 3 writes issued, IDLE after 3 wr_rsp, no DSM write, done=0.
REQ-040 SHALL cover: reset asserted mid-RUN -> all outputs 0 in the same cycle, HELD; num_lines 0 then START -> immediate DSM write.
